// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronise, deglitch, deframe, and buffer scancodes in a show-ahead FIFO.
// Optional PS2_PREFIX_DECODE_EN folds E0/F0 prefixes into the ext/release bits of the next code.
module ps2_rx_fifo #(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_US  = 2000
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          kclk_i,
  input  logic                          kdata_i,
  input  logic                          rd_en_i,
  input  logic                          clr_err_i,
  output logic [9:0]                    data_o,
  output logic                          valid_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] count_o,
  output logic                          err_parity_o,
  output logic                          err_frame_o,
  output logic                          err_overflow_o
);
  localparam int CW     = $clog2(FIFO_DEPTH+1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int FW     = $clog2(FILTER_LEN+1);
  localparam int TO_CYC = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;
  localparam int TW     = $clog2(TO_CYC+1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RECV  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  logic kclk_s1_q, kclk_s2_q, kdata_s1_q, kdata_s2_q;
  logic filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  logic strobe;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      kclk_s1_q  <= 1'b1;
      kclk_s2_q  <= 1'b1;
      kdata_s1_q <= 1'b1;
      kdata_s2_q <= 1'b1;
    end else begin
      kclk_s1_q  <= kclk_i;
      kclk_s2_q  <= kclk_s1_q;
      kdata_s1_q <= kdata_i;
      kdata_s2_q <= kdata_s1_q;
    end
  end

  // Filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      filt_prev_q <= filt_q;
      if (kclk_s2_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN-1)) begin
        filt_q <= kclk_s2_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign strobe = filt_prev_q & ~filt_q;

  logic [1:0]    state_q, state_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    sr_q, sr_d;
  logic [TW-1:0] to_q, to_d;
  logic          to_hit;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    to_d     = '0;
    to_hit   = 1'b0;
    case (state_q)
      S_IDLE: if (strobe && !kdata_s2_q) begin
        state_d  = S_RECV;
        bitcnt_d = 4'd1;
      end
      S_RECV: begin
        if (strobe) begin
          sr_d     = {kdata_s2_q, sr_q[9:1]};
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd10) state_d = S_CHECK;
        end else if (to_q == TW'(TO_CYC-1)) begin
          to_hit  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      sr_q     <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      to_q     <= to_d;
    end
  end

  // After ten shifts: sr_q[9]=stop, sr_q[8]=parity, sr_q[7:0]=code.
  logic       in_check, frame_bad, par_bad, good, push_w;
  logic [7:0] code;
  logic [9:0] push_data;

  assign in_check  = (state_q == S_CHECK);
  assign code      = sr_q[7:0];
  assign frame_bad = in_check & ~sr_q[9];
  assign par_bad   = in_check & sr_q[9] & ~(^sr_q[8:0]);
  assign good      = in_check & sr_q[9] & (^sr_q[8:0]);

`ifdef PS2_PREFIX_DECODE_EN
  logic ext_q, ext_d, rel_q, rel_d, is_e0, is_f0;
  assign is_e0     = (code == 8'hE0);
  assign is_f0     = (code == 8'hF0);
  assign push_w    = good & ~is_e0 & ~is_f0;
  assign push_data = {ext_q, rel_q, code};

  always_comb begin
    ext_d = ext_q;
    rel_d = rel_q;
    if (frame_bad || par_bad || to_hit) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (good) begin
      if (is_e0)      ext_d = 1'b1;
      else if (is_f0) rel_d = 1'b1;
      else begin
        ext_d = 1'b0;
        rel_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      ext_q <= ext_d;
      rel_q <= rel_d;
    end
  end
`else
  assign push_w    = good;
  assign push_data = {2'b00, code};
`endif

  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          empty, full, pop, wr, ovf;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = rd_en_i & ~empty;
  assign wr    = push_w & (~full | pop);
  assign ovf   = push_w & full & ~pop;

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q] <= push_data;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // A new error event in the clearing cycle wins over the clear.
  logic perr_q, ferr_q, oerr_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      perr_q <= (perr_q & ~clr_err_i) | par_bad;
      ferr_q <= (ferr_q & ~clr_err_i) | frame_bad | to_hit;
      oerr_q <= (oerr_q & ~clr_err_i) | ovf;
    end
  end

  assign data_o         = empty ? 10'd0 : mem_q[rptr_q];
  assign valid_o        = ~empty;
  assign full_o         = full;
  assign count_o        = count_q;
  assign err_parity_o   = perr_q;
  assign err_frame_o    = ferr_q;
  assign err_overflow_o = oerr_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of single frames plus hand-written multi-cycle sequences.
// Clock and timeout are scaled down (1 MHz, 200 us) so the run stays short.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int HALF  = 20;

  logic       clk = 1'b0, rst = 1'b1, kclk = 1'b1, kdata = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
  logic [9:0] data;
  logic [3:0] count;
  logic       valid, full, perr, ferr, oerr;
  int         n_vec = 0, n_err = 0;

  ps2_rx_fifo #(
    .CLK_FREQ_HZ(1_000_000), .FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_US(200)
  ) dut (
    .clk_i(clk), .rst_i(rst), .kclk_i(kclk), .kdata_i(kdata), .rd_en_i(rd_en),
    .clr_err_i(clr_err), .data_o(data), .valid_o(valid), .full_o(full), .count_o(count),
    .err_parity_o(perr), .err_frame_o(ferr), .err_overflow_o(oerr)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] code;
    logic       pflip;
    logic       stop;
    logic       push;
    logic       perr;
    logic       ferr;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(input logic [7:0] c, input logic pflip, input logic stop);
    return {stop, (~^c) ^ pflip, c, 1'b0};
  endfunction

  // Host-side frame driver; glitch_at puts a one-cycle low pulse in that bit's high phase.
  task automatic send(input logic [10:0] f, input int nbits, input int glitch_at);
    for (int i = 0; i < nbits; i++) begin
      kdata = f[i];
      if (i == glitch_at) begin
        cyc(HALF/2); kclk = 1'b0; cyc(1); kclk = 1'b1; cyc(HALF/2 - 1);
      end else begin
        cyc(HALF);
      end
      kclk = 1'b0;
      cyc(HALF);
      kclk = 1'b1;
    end
  endtask

  task automatic pop_chk(input string name, input logic [9:0] exp);
    chk(name, data, exp);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
  endtask

  task automatic clr;
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'h16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h16, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{8'h16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    cyc(4);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_errs", {perr, ferr, oerr}, 0);
    rst = 1'b0;
    cyc(5);

    // Push latency: stop-bit fall, strobe after sync+filter, CHECK, then visible.
    send(mk(8'h16, 1'b0, 1'b1), 10, -1);
    kdata = 1'b1; cyc(HALF); kclk = 1'b0;
    cyc(7);
    chk("lat_check_cycle_valid", valid, 0);
    cyc(1);
    chk("lat_push_valid", valid, 1);
    chk("lat_data", data, 10'h016);
    chk("lat_count", count, 1);
    cyc(HALF - 8); kclk = 1'b1; cyc(HALF);
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk("pop_valid", valid, 0);
    chk("pop_count", count, 0);

    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    chk("rd_empty_count", count, 0);
    chk("rd_empty_valid", valid, 0);

    for (int i = 0; i < 8; i++) begin
      send(mk(tbl[i].code, tbl[i].pflip, tbl[i].stop), 11, -1);
      cyc(HALF);
      chk($sformatf("tbl%0d_valid", i), valid, tbl[i].push);
      if (tbl[i].push) begin
        chk($sformatf("tbl%0d_data", i), data, {2'b00, tbl[i].code});
        rd_en = 1'b1; cyc(1); rd_en = 1'b0;
      end
      chk($sformatf("tbl%0d_perr", i), perr, tbl[i].perr);
      chk($sformatf("tbl%0d_ferr", i), ferr, tbl[i].ferr);
      clr();
      chk($sformatf("tbl%0d_clr", i), {perr, ferr, oerr}, 0);
    end

    // Timeout: start + 4 bits then a long idle clock.
    send(mk(8'h33, 1'b0, 1'b1), 5, -1);
    cyc(150);
    chk("to_before", ferr, 0);
    cyc(100);
    chk("to_ferr", ferr, 1);
    chk("to_valid", valid, 0);
    clr();
    send(mk(8'h1C, 1'b0, 1'b1), 11, -1);
    cyc(HALF);
    pop_chk("to_next_data", 10'h01C);
    chk("to_next_ferr", ferr, 0);

    send(mk(8'h16, 1'b0, 1'b1), 11, 4);
    cyc(HALF);
    chk("glitch_count", count, 1);
    chk("glitch_errs", {perr, ferr}, 0);
    pop_chk("glitch_data", 10'h016);

    // Overflow: nine frames into an 8-deep FIFO.
    for (int k = 1; k <= 9; k++) begin
      send(mk(8'(k), 1'b0, 1'b1), 11, -1);
      cyc(HALF);
    end
    chk("ovf_full", full, 1);
    chk("ovf_count", count, DEPTH);
    chk("ovf_err", oerr, 1);
    chk("ovf_head", data, 10'h001);
    clr();
    chk("ovf_clr", oerr, 0);

    // Push and pop in the same cycle while full: pop lands on the CHECK cycle.
    send(mk(8'h0A, 1'b0, 1'b1), 10, -1);
    kdata = 1'b1; cyc(HALF); kclk = 1'b0;
    cyc(7); rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    cyc(HALF - 8); kclk = 1'b1; cyc(HALF);
    chk("pp_count", count, DEPTH);
    chk("pp_full", full, 1);
    chk("pp_oerr", oerr, 0);
    for (int k = 2; k <= 8; k++) pop_chk($sformatf("drain%0d", k), 10'(k));
    pop_chk("drain_0a", 10'h00A);
    chk("drain_empty", valid, 0);

    send(mk(8'hE0, 1'b0, 1'b1), 11, -1); cyc(HALF);
    send(mk(8'hF0, 1'b0, 1'b1), 11, -1); cyc(HALF);
    send(mk(8'h75, 1'b0, 1'b1), 11, -1); cyc(HALF);
`ifdef PS2_PREFIX_DECODE_EN
    chk("pfx_count", count, 1);
    pop_chk("pfx_data", 10'h375);
`else
    chk("pfx_count", count, 3);
    pop_chk("pfx_e0", 10'h0E0);
    pop_chk("pfx_f0", 10'h0F0);
    pop_chk("pfx_75", 10'h075);
`endif
    chk("pfx_empty", valid, 0);

    // Reset mid-frame empties the FIFO and drops the partial frame.
    send(mk(8'h44, 1'b0, 1'b1), 11, -1); cyc(HALF);
    chk("mr_pre_count", count, 1);
    send(mk(8'h55, 1'b0, 1'b1), 5, -1);
    rst = 1'b1; cyc(2); rst = 1'b0;
    chk("mr_count", count, 0);
    chk("mr_valid", valid, 0);
    cyc(HALF);
    send(mk(8'h29, 1'b0, 1'b1), 11, -1); cyc(HALF);
    chk("mr_next_count", count, 1);
    chk("mr_next_errs", {perr, ferr, oerr}, 0);
    pop_chk("mr_next_data", 10'h029);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
